// File: rtl/sobel_window_mac_pkg.sv
// Shared constants for the 3x3 gradient engine: filter modes, coefficient width, FSM states.
`timescale 1ns/1ps
package sobel_window_mac_pkg;
  localparam int COEF_W = 5;

  localparam logic [1:0] MODE_SOBEL   = 2'd0;
  localparam logic [1:0] MODE_PREWITT = 2'd1;
  localparam logic [1:0] MODE_SCHARR  = 2'd2;

  localparam logic [0:0] ST_ACC = 1'b0;
  localparam logic [0:0] ST_OUT = 1'b1;

  typedef logic signed [COEF_W-1:0] coef_t;
endpackage

// File: rtl/sobel_window_mac_coef_rom.sv
// Combinational Gx/Gy coefficient lookup by filter mode and row-major tap index.
// Indices above 8 return zero; the reserved mode falls back to Sobel weights.
`timescale 1ns/1ps
module sobel_window_mac_coef_rom
  import sobel_window_mac_pkg::*;
(
  input  logic [1:0] mode_i,
  input  logic [3:0] idx_i,
  output coef_t      kx_o,
  output coef_t      ky_o
);

  coef_t corner_w;
  coef_t mid_w;

  // All three kernels share one shape: corners weigh corner_w, edge-centres weigh mid_w.
  always_comb begin
    case (mode_i)
      MODE_PREWITT: begin corner_w = 5'sd1; mid_w = 5'sd1;  end
      MODE_SCHARR:  begin corner_w = 5'sd3; mid_w = 5'sd10; end
      default:      begin corner_w = 5'sd1; mid_w = 5'sd2;  end
    endcase
  end

  always_comb begin
    kx_o = '0;
    ky_o = '0;
    case (idx_i)
      4'd0: begin kx_o = -corner_w; ky_o =  corner_w; end
      4'd1: begin kx_o = '0;        ky_o =  mid_w;    end
      4'd2: begin kx_o =  corner_w; ky_o =  corner_w; end
      4'd3: begin kx_o = -mid_w;    ky_o = '0;        end
      4'd5: begin kx_o =  mid_w;    ky_o = '0;        end
      4'd6: begin kx_o = -corner_w; ky_o = -corner_w; end
      4'd7: begin kx_o = '0;        ky_o = -mid_w;    end
      4'd8: begin kx_o =  corner_w; ky_o = -corner_w; end
      default: begin kx_o = '0; ky_o = '0; end
    endcase
  end

endmodule

// File: rtl/sobel_window_mac.sv
// Sequential 3x3 gradient MAC: one pixel per beat, result held in OUT until the downstream handshake.
// Result registered on the 9th beat; Flush_i aborts the window or drops a pending result.
`timescale 1ns/1ps
module sobel_window_mac
  import sobel_window_mac_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int ACC_W = PIX_W + 6
) (
  input  logic                    Clk_i,
  input  logic                    Rst_n_i,
  input  logic                    Flush_i,
  input  logic [1:0]              Mode_i,
  input  logic [PIX_W-1:0]        Thresh_i,
  input  logic [PIX_W-1:0]        Pix_i,
  input  logic                    PixValid_i,
  output logic                    PixReady_o,
  output logic signed [ACC_W-1:0] Gx_o,
  output logic signed [ACC_W-1:0] Gy_o,
  output logic [PIX_W-1:0]        Mag_o,
  output logic                    Edge_o,
  output logic                    ResValid_o,
  input  logic                    ResReady_i
);

  logic [0:0]              state_q, state_d;
  logic [3:0]              idx_q, idx_d;
  logic [1:0]              mode_q, mode_d;
  logic signed [ACC_W-1:0] gx_acc_q, gx_acc_d, gy_acc_q, gy_acc_d;
  logic signed [ACC_W-1:0] gx_q, gx_d, gy_q, gy_d;
  logic [PIX_W-1:0]        mag_q, mag_d;
  logic                    edge_q, edge_d;

  logic [1:0]              rom_mode;
  coef_t                   kx, ky;
  logic signed [ACC_W-1:0] pix_s, kx_s, ky_s, prod_x, prod_y, gx_sum, gy_sum, neg_x, neg_y;
  logic [ACC_W-2:0]        abs_x, abs_y;
  logic [ACC_W-1:0]        mag_sum;
  logic [PIX_W-1:0]        mag_clip;
  logic                    beat;

  // Beat 0 must see the incoming mode, since mode_q is only latched on that same edge.
  assign rom_mode = (idx_q == 4'd0) ? Mode_i : mode_q;

  sobel_window_mac_coef_rom u_coef_rom (
    .mode_i (rom_mode),
    .idx_i  (idx_q),
    .kx_o   (kx),
    .ky_o   (ky)
  );

  assign PixReady_o = (state_q == ST_ACC);
  assign ResValid_o = (state_q == ST_OUT);
  assign beat       = PixValid_i & PixReady_o;

  always_comb begin
    pix_s  = $signed({{(ACC_W-PIX_W){1'b0}}, Pix_i});
    kx_s   = {{(ACC_W-COEF_W){kx[COEF_W-1]}}, kx};
    ky_s   = {{(ACC_W-COEF_W){ky[COEF_W-1]}}, ky};
    prod_x = pix_s * kx_s;
    prod_y = pix_s * ky_s;
    gx_sum = (idx_q == 4'd0) ? prod_x : gx_acc_q + prod_x;
    gy_sum = (idx_q == 4'd0) ? prod_y : gy_acc_q + prod_y;
    neg_x  = -gx_sum;
    neg_y  = -gy_sum;
    abs_x  = gx_sum[ACC_W-1] ? neg_x[ACC_W-2:0] : gx_sum[ACC_W-2:0];
    abs_y  = gy_sum[ACC_W-1] ? neg_y[ACC_W-2:0] : gy_sum[ACC_W-2:0];
    mag_sum  = {1'b0, abs_x} + {1'b0, abs_y};
    mag_clip = (mag_sum[ACC_W-1:PIX_W] != '0) ? '1 : mag_sum[PIX_W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mode_d   = mode_q;
    gx_acc_d = gx_acc_q;
    gy_acc_d = gy_acc_q;
    gx_d     = gx_q;
    gy_d     = gy_q;
    mag_d    = mag_q;
    edge_d   = edge_q;
    if (Flush_i) begin
      state_d  = ST_ACC;
      idx_d    = 4'd0;
      gx_acc_d = '0;
      gy_acc_d = '0;
    end else if (state_q == ST_ACC) begin
      if (beat) begin
        gx_acc_d = gx_sum;
        gy_acc_d = gy_sum;
        if (idx_q == 4'd0) mode_d = Mode_i;
        if (idx_q == 4'd8) begin
          gx_d    = gx_sum;
          gy_d    = gy_sum;
          mag_d   = mag_clip;
          edge_d  = (mag_clip >= Thresh_i);
          idx_d   = 4'd0;
          state_d = ST_OUT;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
    end else if (ResReady_i) begin
      state_d = ST_ACC;
    end
  end

  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      state_q  <= ST_ACC;
      idx_q    <= 4'd0;
      mode_q   <= MODE_SOBEL;
      gx_acc_q <= '0;
      gy_acc_q <= '0;
      gx_q     <= '0;
      gy_q     <= '0;
      mag_q    <= '0;
      edge_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mode_q   <= mode_d;
      gx_acc_q <= gx_acc_d;
      gy_acc_q <= gy_acc_d;
      gx_q     <= gx_d;
      gy_q     <= gy_d;
      mag_q    <= mag_d;
      edge_q   <= edge_d;
    end
  end

  assign Gx_o   = gx_q;
  assign Gy_o   = gy_q;
  assign Mag_o  = mag_q;
  assign Edge_o = edge_q;

endmodule

// File: tb/tb_sobel_window_mac.sv
// Directed plus randomized bench for sobel_window_mac against a plain-arithmetic convolution model.
`timescale 1ns/1ps
module tb_sobel_window_mac;
  localparam int PIX_W = 8;
  localparam int ACC_W = PIX_W + 6;

  logic                    Clk_i = 1'b0;
  logic                    Rst_n_i, Flush_i, PixValid_i, ResReady_i;
  logic [1:0]              Mode_i;
  logic [PIX_W-1:0]        Thresh_i, Pix_i;
  logic                    PixReady_o, Edge_o, ResValid_o;
  logic signed [ACC_W-1:0] Gx_o, Gy_o;
  logic [PIX_W-1:0]        Mag_o;

  int checks = 0;
  int errors = 0;
  int win[9];
  int exp_mode, exp_thresh, exp_gx, exp_gy, exp_mag, exp_edge;

  sobel_window_mac #(.PIX_W(PIX_W), .ACC_W(ACC_W)) dut (
    .Clk_i(Clk_i), .Rst_n_i(Rst_n_i), .Flush_i(Flush_i), .Mode_i(Mode_i),
    .Thresh_i(Thresh_i), .Pix_i(Pix_i), .PixValid_i(PixValid_i), .PixReady_o(PixReady_o),
    .Gx_o(Gx_o), .Gy_o(Gy_o), .Mag_o(Mag_o), .Edge_o(Edge_o),
    .ResValid_o(ResValid_o), .ResReady_i(ResReady_i)
  );

  always #5 Clk_i = ~Clk_i;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Kernel weight from the textbook definition: horizontal kernel weights columns, vertical weights rows.
  function automatic int coef(input int mode, input bit is_y, input int idx);
    int r, c, cw, mw, w;
    r = idx / 3;
    c = idx % 3;
    if (mode == 1) begin cw = 1; mw = 1; end
    else if (mode == 2) begin cw = 3; mw = 10; end
    else begin cw = 1; mw = 2; end
    if (!is_y) begin
      w = (r == 1) ? mw : cw;
      return (c == 0) ? -w : (c == 2) ? w : 0;
    end
    w = (c == 1) ? mw : cw;
    return (r == 0) ? w : (r == 2) ? -w : 0;
  endfunction

  task automatic model();
    int ax, ay;
    exp_gx = 0;
    exp_gy = 0;
    for (int i = 0; i < 9; i++) begin
      exp_gx += win[i] * coef(exp_mode, 1'b0, i);
      exp_gy += win[i] * coef(exp_mode, 1'b1, i);
    end
    ax = (exp_gx < 0) ? -exp_gx : exp_gx;
    ay = (exp_gy < 0) ? -exp_gy : exp_gy;
    exp_mag  = (ax + ay > 255) ? 255 : ax + ay;
    exp_edge = (exp_mag >= exp_thresh) ? 1 : 0;
  endtask

  task automatic send_beat(input int p);
    bit rdy;
    bit done;
    done = 1'b0;
    @(negedge Clk_i);
    Pix_i = p[PIX_W-1:0];
    PixValid_i = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      rdy = PixReady_o;
      @(posedge Clk_i);
      if (rdy) done = 1'b1;
      else @(negedge Clk_i);
    end
    #1 PixValid_i = 1'b0;
    if (!done) check("beat_timeout", 0, 1);
  endtask

  // Sends the first n beats of win[]; Mode_i is scrambled after beat 0 to prove it is latched once.
  task automatic send_beats(input int n, input int mode, input int max_gap);
    Mode_i = mode[1:0];
    exp_mode = mode;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, max_gap)) @(negedge Clk_i);
      send_beat(win[i]);
      if (i == 0) Mode_i = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic run_window(input string tag, input int mode, input int thresh, input int max_gap);
    exp_thresh = thresh;
    Thresh_i = thresh[PIX_W-1:0];
    send_beats(9, mode, max_gap);
    model();
    @(negedge Clk_i);
    check({tag, "_latency_vld"}, 32'(ResValid_o), 1);
    check({tag, "_gx"}, Gx_o, exp_gx);
    check({tag, "_gy"}, Gy_o, exp_gy);
    check({tag, "_mag"}, 32'(Mag_o), exp_mag);
    check({tag, "_edge"}, 32'(Edge_o), exp_edge);
    check({tag, "_rdy_low"}, 32'(PixReady_o), 0);
  endtask

  task automatic handshake(input string tag);
    @(negedge Clk_i);
    ResReady_i = 1'b1;
    @(posedge Clk_i);
    #1 ResReady_i = 1'b0;
    @(negedge Clk_i);
    check({tag, "_vld_drop"}, 32'(ResValid_o), 0);
    check({tag, "_rdy_back"}, 32'(PixReady_o), 1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 9; i++) win[i] = $urandom_range(0, 255);
  endtask

  initial begin
    Rst_n_i = 1'b0; Flush_i = 1'b0; PixValid_i = 1'b0; ResReady_i = 1'b0;
    Mode_i = 2'd0; Thresh_i = '0; Pix_i = '0;
    repeat (2) @(negedge Clk_i);
    check("rst_gx", Gx_o, 0);
    check("rst_gy", Gy_o, 0);
    check("rst_mag", 32'(Mag_o), 0);
    check("rst_edge", 32'(Edge_o), 0);
    check("rst_vld", 32'(ResValid_o), 0);
    check("rst_rdy", 32'(PixReady_o), 1);
    Rst_n_i = 1'b1;

    // Flat window: no gradient.
    for (int i = 0; i < 9; i++) win[i] = 255;
    run_window("flat", 0, 1, 0);
    check("flat_gx_const", Gx_o, 0);
    check("flat_edge_const", 32'(Edge_o), 0);
    handshake("flat");

    // Vertical step edge, Sobel then Scharr.
    for (int i = 0; i < 9; i++) win[i] = (i % 3 == 2) ? 255 : 0;
    run_window("sobel_step", 0, 100, 0);
    check("sobel_step_gx_const", Gx_o, 1020);
    check("sobel_step_mag_const", 32'(Mag_o), 255);
    check("sobel_step_edge_const", 32'(Edge_o), 1);
    handshake("sobel_step");
    run_window("scharr_step", 2, 100, 0);
    check("scharr_step_gx_const", Gx_o, 4080);
    check("scharr_step_gy_const", Gy_o, 0);
    handshake("scharr_step");

    // Horizontal step, Prewitt; then hold the result with extra pixel beats offered.
    for (int i = 0; i < 9; i++) win[i] = (i < 3) ? 255 : 0;
    run_window("prewitt_row", 1, 50, 0);
    check("prewitt_row_gx_const", Gx_o, 0);
    check("prewitt_row_gy_const", Gy_o, 765);
    @(negedge Clk_i);
    PixValid_i = 1'b1;
    Pix_i = 8'hAA;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk_i);
      check("hold_gy", Gy_o, 765);
      check("hold_vld", 32'(ResValid_o), 1);
      check("hold_rdy", 32'(PixReady_o), 0);
    end
    PixValid_i = 1'b0;
    handshake("hold");
    fill_random();
    run_window("after_hold", 0, 30, 0);
    handshake("after_hold");

    // Gapped beats with Mode_i scrambled after beat 0.
    fill_random();
    run_window("gaps", 2, 200, 3);
    handshake("gaps");

    // Flush at beat 4: partial window discarded, flush wins over the offered beat.
    fill_random();
    send_beats(4, 1, 1);
    @(negedge Clk_i);
    Flush_i = 1'b1;
    PixValid_i = 1'b1;
    Pix_i = 8'hFF;
    @(posedge Clk_i);
    #1 Flush_i = 1'b0;
    PixValid_i = 1'b0;
    @(negedge Clk_i);
    check("flush_acc_vld", 32'(ResValid_o), 0);
    fill_random();
    run_window("post_flush", 0, 40, 1);

    // Flush while a result is pending drops it.
    @(negedge Clk_i);
    Flush_i = 1'b1;
    @(posedge Clk_i);
    #1 Flush_i = 1'b0;
    @(negedge Clk_i);
    check("flush_out_vld", 32'(ResValid_o), 0);
    check("flush_out_rdy", 32'(PixReady_o), 1);

    // Async reset at beat 6.
    fill_random();
    send_beats(6, 2, 1);
    @(negedge Clk_i);
    Rst_n_i = 1'b0;
    #1;
    check("arst_gx", Gx_o, 0);
    check("arst_vld", 32'(ResValid_o), 0);
    check("arst_rdy", 32'(PixReady_o), 1);
    @(negedge Clk_i);
    Rst_n_i = 1'b1;
    fill_random();
    run_window("post_rst", 1, 20, 1);
    handshake("post_rst");

    for (int w = 0; w < 20; w++) begin
      fill_random();
      run_window("rand", $urandom_range(0, 3), $urandom_range(0, 255), 2);
      handshake("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    check("global_timeout", 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "FAIL global_timeout: simulation did not complete");
  end

endmodule
